// File: rtl/pbit_hist_pkg.sv
// ============================================================================
//  Module   : pbit_hist_pkg
//  Purpose  : Shared FSM encoding, default widths and the saturating increment
//             used by the p-bit sample histogrammer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package pbit_hist_pkg;

    localparam int STATE_W_DEF = 8;
    localparam int COUNT_W_DEF = 16;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_ACQ   = 2'd2;
    localparam logic [1:0] ST_READ  = 2'd3;

    // Returns the input unchanged when already at the ceiling, so a caller can
    // detect a blocked increment by comparing result and input.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                            input logic [31:0] max_v);
        return (cnt >= max_v) ? cnt : cnt + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pbit_hist_bins.sv
// ============================================================================
//  Module   : pbit_hist_bins
//  Purpose  : 2^STATE_W x COUNT_W bin array, one clear/increment write port and
//             one registered read port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pbit_hist_bins
    import pbit_hist_pkg::*;
#(
    parameter int STATE_W = STATE_W_DEF,
    parameter int COUNT_W = COUNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               we_i,
    input  logic               clr_i,
    input  logic [STATE_W-1:0] waddr_i,
    input  logic               rd_en_i,
    input  logic [STATE_W-1:0] raddr_i,
    output logic [COUNT_W-1:0] rdata_o,
    output logic               sat_o
);

    localparam int          NBINS   = 1 << STATE_W;
    localparam logic [31:0] CNT_MAX = 32'((64'd1 << COUNT_W) - 64'd1);

    logic [COUNT_W-1:0] mem_q [NBINS];
    logic [COUNT_W-1:0] rdata_q;
    logic [31:0]        cur_ext;
    logic [31:0]        inc_res;

    assign cur_ext = 32'(mem_q[waddr_i]);
    assign inc_res = sat_inc(cur_ext, CNT_MAX);
    assign sat_o   = we_i & ~clr_i & (inc_res == cur_ext);

    // Bin storage needs no reset: every run clears it before acquiring.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= clr_i ? '0 : inc_res[COUNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/pbit_sample_histogrammer.sv
// ============================================================================
//  Module   : pbit_sample_histogrammer
//  Purpose  : Samples the p-bit output word once per sweep, histograms it and
//             streams the bins out over a valid/ready port.
//             Optional burn-in: define PBIT_HIST_BURNIN_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pbit_sample_histogrammer
    import pbit_hist_pkg::*;
#(
    parameter int STATE_W = STATE_W_DEF,
    parameter int COUNT_W = COUNT_W_DEF,
    parameter int NSAMP_W = 24
`ifdef PBIT_HIST_BURNIN_EN
    ,
    parameter int BURNIN  = 16
`endif
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start_i,
    input  logic [NSAMP_W-1:0] num_samples_i,
    input  logic [STATE_W-1:0] state_in_i,
    input  logic               sweep_done_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               rd_valid_o,
    input  logic               rd_ready_i,
    output logic [STATE_W-1:0] rd_bin_o,
    output logic [COUNT_W-1:0] rd_count_o,
    output logic               sat_flag_o
);

    localparam int                 NBINS    = 1 << STATE_W;
    localparam logic [STATE_W-1:0] LAST_BIN = STATE_W'(NBINS - 1);

    logic [1:0]         state_q, state_d;
    logic [NSAMP_W-1:0] nsamp_q, nsamp_d;
    logic [NSAMP_W-1:0] cnt_q, cnt_d;
    logic [STATE_W-1:0] idx_q, idx_d;
    logic               sat_q, sat_d;
    logic               done_q, done_d;

    logic               start_acc;
    logic               acq_strobe;
    logic               rec_strobe;
    logic               bin_we;
    logic               bin_clr;
    logic               bin_sat;
    logic [STATE_W-1:0] bin_waddr;

    assign start_acc  = (state_q == ST_IDLE) & start_i & ~done_q;
    assign acq_strobe = (state_q == ST_ACQ) & (cnt_q != nsamp_q) & sweep_done_i;

`ifdef PBIT_HIST_BURNIN_EN
    localparam int BURN_W = $clog2(BURNIN + 1) + 1;

    logic [BURN_W-1:0] burn_q, burn_d;
    logic              burn_left;

    assign burn_left  = (burn_q != BURN_W'(BURNIN));
    assign rec_strobe = acq_strobe & ~burn_left;

    always_comb begin
        burn_d = burn_q;
        if (start_acc) begin
            burn_d = '0;
        end else if (acq_strobe && burn_left) begin
            burn_d = burn_q + BURN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            burn_q <= '0;
        end else begin
            burn_q <= burn_d;
        end
    end
`else
    assign rec_strobe = acq_strobe;
`endif

    // idx_q doubles as the clear pointer and the readout bin; it wraps to 0
    // at the end of CLEAR, which is exactly where readout must begin.
    always_comb begin
        state_d = state_q;
        nsamp_d = nsamp_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_acc) begin
                    state_d = ST_CLEAR;
                    nsamp_d = num_samples_i;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_CLEAR: begin
                idx_d = idx_q + STATE_W'(1);
                if (idx_q == LAST_BIN) begin
                    state_d = (nsamp_q == '0) ? ST_READ : ST_ACQ;
                end
            end
            ST_ACQ: begin
                if (cnt_q == nsamp_q) begin
                    state_d = ST_READ;
                end else if (rec_strobe) begin
                    cnt_d = cnt_q + NSAMP_W'(1);
                end
            end
            ST_READ: begin
                if (rd_ready_i) begin
                    idx_d = idx_q + STATE_W'(1);
                    if (idx_q == LAST_BIN) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign sat_d = start_acc ? 1'b0 : (sat_q | bin_sat);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            nsamp_q <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            sat_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            nsamp_q <= nsamp_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sat_q   <= sat_d;
            done_q  <= done_d;
        end
    end

    assign bin_clr   = (state_q == ST_CLEAR);
    assign bin_we    = bin_clr | rec_strobe;
    assign bin_waddr = bin_clr ? idx_q : state_in_i;

    // Reading at the next index keeps rd_count aligned with rd_bin, and
    // re-reading the same bin while stalled leaves it unchanged.
    pbit_hist_bins #(
        .STATE_W (STATE_W),
        .COUNT_W (COUNT_W)
    ) u_bins (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (bin_we),
        .clr_i   (bin_clr),
        .waddr_i (bin_waddr),
        .rd_en_i (state_d == ST_READ),
        .raddr_i (idx_d),
        .rdata_o (rd_count_o),
        .sat_o   (bin_sat)
    );

    assign busy_o     = (state_q != ST_IDLE);
    assign rd_valid_o = (state_q == ST_READ);
    assign rd_bin_o   = idx_q;
    assign done_o     = done_q;
    assign sat_flag_o = sat_q;

endmodule

`default_nettype wire

// File: tb/tb_pbit_sample_histogrammer.sv
// ============================================================================
//  Module   : tb_pbit_sample_histogrammer
//  Purpose  : Randomised self-checking bench; a 16-bit and a 4-bit-counter
//             instance share all stimulus and are checked against one model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pbit_sample_histogrammer;

    localparam int STATE_W   = 8;
    localparam int COUNT_W   = 16;
    localparam int COUNT_W_S = 4;
    localparam int NSAMP_W   = 24;
    localparam int NBINS     = 256;
`ifdef PBIT_HIST_BURNIN_EN
    localparam int BURNIN    = 16;
`else
    localparam int BURNIN    = 0;
`endif

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 start_i;
    logic [NSAMP_W-1:0]   num_samples_i;
    logic [STATE_W-1:0]   state_in_i;
    logic                 sweep_done_i;
    logic                 rd_ready_i;
    logic                 busy_a, done_a, valid_a, sat_a;
    logic                 busy_b, done_b, valid_b, sat_b;
    logic [STATE_W-1:0]   bin_a, bin_b;
    logic [COUNT_W-1:0]   cnt_a;
    logic [COUNT_W_S-1:0] cnt_b;

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt [NBINS];

    always #5 clk = ~clk;

    pbit_sample_histogrammer #(.STATE_W(STATE_W), .COUNT_W(COUNT_W), .NSAMP_W(NSAMP_W)) u_dut (
        .clk(clk), .reset_n(reset_n), .start_i(start_i), .num_samples_i(num_samples_i),
        .state_in_i(state_in_i), .sweep_done_i(sweep_done_i), .busy_o(busy_a), .done_o(done_a),
        .rd_valid_o(valid_a), .rd_ready_i(rd_ready_i), .rd_bin_o(bin_a), .rd_count_o(cnt_a),
        .sat_flag_o(sat_a)
    );

    pbit_sample_histogrammer #(.STATE_W(STATE_W), .COUNT_W(COUNT_W_S), .NSAMP_W(NSAMP_W)) u_dut_s (
        .clk(clk), .reset_n(reset_n), .start_i(start_i), .num_samples_i(num_samples_i),
        .state_in_i(state_in_i), .sweep_done_i(sweep_done_i), .busy_o(busy_b), .done_o(done_b),
        .rd_valid_o(valid_b), .rd_ready_i(rd_ready_i), .rd_bin_o(bin_b), .rd_count_o(cnt_b),
        .sat_flag_o(sat_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int cap(input int c, input int w);
        int m;
        m = (1 << w) - 1;
        return (c > m) ? m : c;
    endfunction

    function automatic bit any_over(input int w);
        for (int i = 0; i < NBINS; i++) begin
            if (exp_cnt[i] > (1 << w) - 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    // rmode: 0 always ready, 1 ready toggles every cycle, 2 random ready
    task automatic readout(input int rmode);
        int b;
        int cyc;
        b   = 0;
        cyc = 0;
        while (b < NBINS && cyc < 4000) begin
            chk("rd_valid",   valid_a, 1);
            chk("rd_valid_s", valid_b, 1);
            chk("rd_bin",     bin_a, b);
            chk("rd_bin_s",   bin_b, b);
            chk("rd_count",   cnt_a, cap(exp_cnt[b], COUNT_W));
            chk("rd_count_s", cnt_b, cap(exp_cnt[b], COUNT_W_S));
            chk("done_early", done_a, 0);
            case (rmode)
                0:       rd_ready_i = 1'b1;
                1:       rd_ready_i = (cyc % 2 == 0);
                default: rd_ready_i = 1'($urandom_range(0, 1));
            endcase
            sweep_done_i = 1'($urandom_range(0, 1));
            state_in_i   = 8'($urandom);
            if (rd_ready_i) b++;
            step();
            cyc++;
        end
        rd_ready_i   = 1'b0;
        sweep_done_i = 1'b0;
        chk("done_pulse",    done_a, 1);
        chk("done_pulse_s",  done_b, 1);
        chk("valid_dropped", valid_a, 0);
        chk("busy_dropped",  busy_a, 0);
        chk("sat_flag",      sat_a, any_over(COUNT_W));
        chk("sat_flag_s",    sat_b, any_over(COUNT_W_S));
        // a start coinciding with done must be ignored
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("start_on_done_ignored", busy_a, 0);
        chk("done_one_cycle",        done_a, 0);
    endtask

    // mode: 0 constant va, 1 alternate va/vb, 2 random gaps and mostly va/vb
    task automatic run(input int n, input int mode, input logic [7:0] va, input logic [7:0] vb,
                       input int rmode, input bit poke_start);
        int burn;
        int rec;
        int k;
        int guard;
        logic [7:0] v;
        bit sd;
        for (int i = 0; i < NBINS; i++) exp_cnt[i] = 0;
        num_samples_i = NSAMP_W'(n);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("busy_after_start", busy_a, 1);
        chk("sat_cleared",      sat_a, 0);
        chk("sat_cleared_s",    sat_b, 0);
        // noise during CLEAR, including the CLEAR->next transition cycle
        for (int i = 0; i < NBINS; i++) begin
            sweep_done_i = 1'($urandom_range(0, 1));
            state_in_i   = 8'($urandom);
            step();
        end
        sweep_done_i = 1'b0;
        if (n != 0) begin
            chk("acq_entered", {30'd0, valid_a, busy_a}, 32'd1);
            burn = 0; rec = 0; k = 0; guard = 0;
            while (rec < n && guard < 20000) begin
                sd = (mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (mode == 0)                          v = va;
                else if (mode == 1)                     v = k[0] ? vb : va;
                else if ($urandom_range(0, 3) == 0)     v = 8'($urandom);
                else                                    v = k[0] ? vb : va;
                sweep_done_i = sd;
                state_in_i   = v;
                start_i      = poke_start && (k == n / 2);
                if (sd) begin
                    if (burn < BURNIN) burn++;
                    else begin
                        exp_cnt[v]++;
                        rec++;
                    end
                    k++;
                end
                step();
                guard++;
            end
            start_i = 1'b0;
            chk("acq_holds_after_last", {30'd0, valid_a, busy_a}, 32'd1);
            // strobe in the cycle before READOUT must not be counted
            sweep_done_i = 1'b1;
            state_in_i   = va;
            step();
            sweep_done_i = 1'b0;
        end
        readout(rmode);
    endtask

    initial begin
        reset_n       = 1'b0;
        start_i       = 1'b0;
        num_samples_i = '0;
        state_in_i    = '0;
        sweep_done_i  = 1'b0;
        rd_ready_i    = 1'b0;
        repeat (3) step();
        chk("rst_busy",     busy_a, 0);
        chk("rst_done",     done_a, 0);
        chk("rst_valid",    valid_a, 0);
        chk("rst_bin",      bin_a, 0);
        chk("rst_count",    cnt_a, 0);
        chk("rst_sat",      sat_a, 0);
        chk("rst_count_s",  cnt_b, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        run(10,  0, 8'h8F, 8'h8F, 0, 1'b0);
        run(100, 1, 8'h23, 8'h51, 1, 1'b1);
        run(20,  0, 8'h05, 8'h05, 2, 1'b0);
        run(0,   0, 8'h00, 8'h00, 2, 1'b0);
        for (int r = 0; r < 5; r++) begin
            run($urandom_range(1, 60), 2, 8'($urandom), 8'($urandom), 2, 1'($urandom_range(0, 1)));
        end

        // abort mid-ACQUIRE
        num_samples_i = NSAMP_W'(50);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        repeat (NBINS + 5) begin
            sweep_done_i = 1'b1;
            state_in_i   = 8'($urandom);
            step();
        end
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy",  busy_a, 0);
        chk("abort_valid", valid_a, 0);
        chk("abort_done",  done_a, 0);
        chk("abort_bin",   bin_a, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sweep_done_i = 1'($urandom_range(0, 1));
            step();
            chk("abort_no_done", {30'd0, done_a, busy_a}, 32'd0);
        end
        sweep_done_i = 1'b0;

        run(3, 0, 8'hAA, 8'hAA, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pbit_sample_histogrammer.md
Name: pbit_sample_histogrammer

Overview:
- Downstream consumer of the p-bit network's 8-bit clamped-output word.
- Samples the word once per completed sweep and accumulates a 2^STATE_W-bin histogram of observed states (e.g. factor candidates for integer factorisation).
- Streams the histogram out over a valid/ready read port for host or UART readout.
- Sits between the probabilistic top level and the readout/communication logic.

Parameters:
- STATE_W, 8, width of sampled output word; bins = 2^STATE_W.
- COUNT_W, 16, width of each bin counter.
- NSAMP_W, 24, width of the num_samples request.
- BURNIN, 16, sweeps discarded before counting (only used when the optional feature is enabled).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begin a clear/acquire/readout run.
- num_samples  in  NSAMP_W  sweeps to record; latched on start.
- state_in  in  STATE_W  p-bit output word; bit k = network output k.
- sweep_done  in  1  single-cycle strobe from the sequencer at group wrap-around.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the last bin is accepted.
- rd_valid  out  1  readout data valid.
- rd_ready  in  1  readout consumer ready.
- rd_bin  out  STATE_W  bin index of current readout word.
- rd_count  out  COUNT_W  count of that bin.
- sat_flag  out  1  sticky; some bin saturated during this run.

Behaviour:
- Reset: FSM to IDLE; busy=0, done=0, rd_valid=0, rd_bin=0, rd_count=0, sat_flag=0; sample counter=0. Bin contents are don't-care; they are cleared on every start.
- FSM states: IDLE -> CLEAR -> ACQUIRE -> READOUT -> IDLE.
- IDLE:
  - start=1 latches num_samples, clears sat_flag, and goes to CLEAR.
  - start while not IDLE is ignored.
- CLEAR:
  - Writes 0 to one bin per cycle, bin 0 first, 2^STATE_W cycles total.
  - sweep_done is ignored.
  - After the last bin: go to ACQUIRE, or directly to READOUT if the latched num_samples==0.
- ACQUIRE:
  - On sweep_done=1, state_in is sampled that cycle.
  - bin[state_in] increments by 1 and the sample counter increments.
  - Latency: the updated count is visible to any read 1 cycle later.
  - Saturation: a bin at 2^COUNT_W-1 holds its value and sets sat_flag.
  - When the counter reaches the latched num_samples, go to READOUT the next cycle. No further sweep_done is counted.
- READOUT:
  - rd_valid=1; rd_bin runs 0..2^STATE_W-1; rd_count=bin[rd_bin], registered.
  - A bin is transferred when rd_valid & rd_ready.
  - rd_bin/rd_count hold stable while rd_valid=1 and rd_ready=0.
  - After the transfer of the last bin: rd_valid=0, done pulses 1 cycle, go to IDLE.
- Simultaneous events:
  - sweep_done in the same cycle as the CLEAR->ACQUIRE transition is not counted.
  - start in the same cycle as done is ignored.
- Reset mid-run: immediate return to IDLE; the run is aborted and no done pulse is produced.

Optional Feature:
- Macro: PBIT_HIST_BURNIN_EN.
- Defined:
  - ACQUIRE first discards BURNIN sweep_done strobes, counted by a separate burn-in counter.
  - Recording begins with the next strobe; num_samples counts only recorded sweeps.
  - With num_samples==0, the FSM skips burn-in and ACQUIRE and goes from CLEAR directly to READOUT.
- Undefined: no burn-in counter; recording starts with the first strobe in ACQUIRE.

Decomposition:
- Shared package pbit_hist_pkg holds:
  - the FSM state enum (ST_IDLE, ST_CLEAR, ST_ACQ, ST_READ);
  - default STATE_W/COUNT_W constants;
  - the saturating-increment function.
- Sub-module pbit_hist_bins: 2^STATE_W x COUNT_W register array.
  - One write port: clear or saturating increment.
  - One registered read port for readout.
  - sat output when an increment is blocked.

Test Plan:
- Constant state: state_in=8'h8F, num_samples=10, 10 sweep_done strobes -> bin 0x8F reads 10, all other bins 0, done after 256 accepted reads.
- Alternating states: state_in alternates 8'h23/8'h51 over 100 strobes -> bins 0x23 and 0x51 each read 50.
- Backpressure: rd_ready toggled 1/0 every cycle -> no bin skipped or duplicated; rd_bin/rd_count stable while stalled; 256 transfers in total.
- Saturation: COUNT_W=4, 20 strobes with state_in=8'h05 -> bin 0x05 reads 15, sat_flag=1.
- Zero samples and clear masking: num_samples=0 -> READOUT straight after CLEAR, all bins 0; strobes during CLEAR not counted; start during ACQUIRE ignored.
- Reset and burn-in: reset_n low mid-ACQUIRE -> busy=0, rd_valid=0, no done. With PBIT_HIST_BURNIN_EN, BURNIN=16, num_samples=4 and 20 strobes -> only strobes 17-20 are counted.
